// File: rtl/axi4_master_slave.sv
// AXI4 burst master and word-addressed memory slave joined by full AW/W/B/AR/R
// channels. The master runs one fixed INCR write burst or read burst per start
// pulse. The slave stores writes in a small memory and returns reads from it.
// Handshake rule on every channel: a beat transfers only in a cycle where VALID
// and READY are both high. Once VALID is up, it and its payload hold steady
// until that cycle.

module axi4_master #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned BASE_ADDR = 32'h4,
  parameter logic [DATA_W-1:0] BASE_DATA = DATA_W'(32'hdeadbeef)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_write,
  input  logic              start_read,
  output logic              write_done,
  output logic              read_done,
  output logic              busy,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  input  logic [7:0]        rbuf_dbg_addr,
  output logic [DATA_W-1:0] rbuf_dbg_data
);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam logic [2:0] SIZE_CODE = 3'($clog2(DATA_W/8));

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;
  state_t state;

  logic [7:0]        wbeat_q;
  logic [7:0]        rbeat_q;
  logic [DATA_W-1:0] rbuf [MEM_DEPTH];
  logic [IDX_W-1:0]  rbuf_idx;
  logic              r_ok;

  // Address phase payload is fixed for every burst, so it is trivially stable.
  assign awid    = 4'd0;
  assign awaddr  = ADDR_W'(BASE_ADDR);
  assign awlen   = 8'(BURST_LEN - 1);
  assign awsize  = SIZE_CODE;
  assign awburst = 2'b01;
  assign wstrb   = '1;
  assign arid    = 4'd0;
  assign araddr  = ADDR_W'(BASE_ADDR);
  assign arlen   = 8'(BURST_LEN - 1);
  assign arsize  = SIZE_CODE;
  assign arburst = 2'b01;
  assign busy    = (state != IDLE);

  // Beat i of the read burst lands at word (ARADDR + i) mod depth.
  assign rbuf_idx = IDX_W'((ADDR_W'(BASE_ADDR) + ADDR_W'(rbeat_q)) % ADDR_W'(MEM_DEPTH));
  // An error response or a foreign ID is stored as zero, so bad data is never kept.
  assign r_ok = (rresp == 2'b00) && (rid == 4'd0);
  assign rbuf_dbg_data = (32'(rbuf_dbg_addr) < MEM_DEPTH) ? rbuf[IDX_W'(rbuf_dbg_addr)] : '0;

  // Master FSM with registered channel controls, done pulses and read buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      wdata      <= '0;
      wlast      <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      wbeat_q    <= '0;
      rbeat_q    <= '0;
      write_done <= 1'b0;
      read_done  <= 1'b0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) rbuf[i] <= '0;
    end else begin
      write_done <= 1'b0;
      read_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_write) begin
            state   <= WADDR;
            awvalid <= 1'b1;
          end else if (start_read) begin
            state   <= RADDR;
            arvalid <= 1'b1;
          end
        end
        WADDR: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wdata   <= BASE_DATA;
            wlast   <= (BURST_LEN == 1);
            wbeat_q <= '0;
            state   <= WDATA;
          end
        end
        WDATA: begin
          if (wvalid && wready) begin
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= WRESP;
            end else begin
              wbeat_q <= wbeat_q + 8'd1;
              wdata   <= wdata + DATA_W'(1);
              wlast   <= (32'(wbeat_q) + 32'd2 == BURST_LEN);
            end
          end
        end
        WRESP: begin
          if (bvalid && bready) begin
            bready     <= 1'b0;
            // write_done reports a clean completion of our own burst.
            write_done <= (bresp == 2'b00) && (bid == 4'd0);
            state      <= IDLE;
          end
        end
        RADDR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            rbeat_q <= '0;
            state   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid && rready) begin
            rbuf[rbuf_idx] <= r_ok ? rdata : '0;
            rbeat_q        <= rbeat_q + 8'd1;
            if (rlast) begin
              rready    <= 1'b0;
              read_done <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module axi4_slave #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [3:0]        arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [7:0]        mem_dbg_addr,
  output logic [DATA_W-1:0] mem_dbg_data
);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [2:0] SIZE_CODE = 3'($clog2(DATA_W/8));

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] waddr_q, raddr_q;
  logic [7:0]        awlen_q, arlen_q, wbeat_q, rbeat_q;
  logic [3:0]        awid_q, arid_q;
  logic              wincr_q, rincr_q, wsize_ok_q, rsize_ok_q;
  logic [IDX_W-1:0]  w_idx, r_idx;

  // Word index wraps at the memory depth.
  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a % ADDR_W'(MEM_DEPTH));
  endfunction

  assign w_idx   = to_idx(waddr_q);
  assign r_idx   = to_idx(raddr_q);
  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bid     = awid_q;
  // A beat size other than the full bus width is answered with SLVERR.
  assign bresp   = wsize_ok_q ? 2'b00 : 2'b10;
  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign rid     = arid_q;
  assign rresp   = rsize_ok_q ? 2'b00 : 2'b10;
  assign rlast   = (rbeat_q == arlen_q);
  assign rdata   = mem[r_idx];
  assign mem_dbg_data = (32'(mem_dbg_addr) < MEM_DEPTH) ? mem[IDX_W'(mem_dbg_addr)] : '0;

  // Write FSM: accept address, take strobed beats into mem, then respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state    <= W_IDLE;
      waddr_q    <= '0;
      awlen_q    <= '0;
      awid_q     <= '0;
      wbeat_q    <= '0;
      wincr_q    <= 1'b0;
      wsize_ok_q <= 1'b0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            waddr_q    <= awaddr;
            awlen_q    <= awlen;
            awid_q     <= awid;
            wincr_q    <= (awburst == 2'b01);
            wsize_ok_q <= (awsize == SIZE_CODE);
            wbeat_q    <= '0;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
              if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
            wbeat_q <= wbeat_q + 8'd1;
            if (wincr_q) waddr_q <= waddr_q + ADDR_W'(1);
            // Stop on WLAST or once AWLEN+1 beats are in, whichever is first.
            if (wlast || (wbeat_q == awlen_q)) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: accept address, then stream beats out of mem until RLAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= R_IDLE;
      raddr_q    <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
      rbeat_q    <= '0;
      rincr_q    <= 1'b0;
      rsize_ok_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            raddr_q    <= araddr;
            arlen_q    <= arlen;
            arid_q     <= arid;
            rincr_q    <= (arburst == 2'b01);
            rsize_ok_q <= (arsize == SIZE_CODE);
            rbeat_q    <= '0;
            r_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            rbeat_q <= rbeat_q + 8'd1;
            if (rincr_q) raddr_q <= raddr_q + ADDR_W'(1);
            if (rlast) r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

module axi4_master_slave #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned BASE_ADDR = 32'h4,
  parameter logic [DATA_W-1:0] BASE_DATA = DATA_W'(32'hdeadbeef)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start_write,
  input  logic              start_read,
  output logic              write_done,
  output logic              read_done,
  output logic              busy,
  input  logic [7:0]        mem_dbg_addr,
  output logic [DATA_W-1:0] mem_dbg_data,
  input  logic [7:0]        rbuf_dbg_addr,
  output logic [DATA_W-1:0] rbuf_dbg_data
);
  logic [3:0]        awid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;

  axi4_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH),
    .BURST_LEN(BURST_LEN), .BASE_ADDR(BASE_ADDR), .BASE_DATA(BASE_DATA)
  ) u_master (
    .clk(aclk), .reset(areset), .start_write(start_write), .start_read(start_read),
    .write_done(write_done), .read_done(read_done), .busy(busy),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .rbuf_dbg_addr(rbuf_dbg_addr), .rbuf_dbg_data(rbuf_dbg_data)
  );

  axi4_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)
  ) u_slave (
    .clk(aclk), .reset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_dbg_addr(mem_dbg_addr), .mem_dbg_data(mem_dbg_data)
  );
endmodule

// File: tb/tb_axi4_master_slave.sv
// Directed bench for axi4_master_slave: reset, read-before-write, write, read,
// start priority / busy, and reset in the middle of a write burst.

module tb_axi4_master_slave;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start_write = 1'b0;
  logic        start_read = 1'b0;
  logic        write_done, read_done, busy;
  logic [7:0]  mem_dbg_addr = 8'd0;
  logic [31:0] mem_dbg_data;
  logic [7:0]  rbuf_dbg_addr = 8'd0;
  logic [31:0] rbuf_dbg_data;

  int checks = 0;
  int failures = 0;
  int wd_cnt = 0, rd_cnt = 0, w_beats = 0, r_beats = 0, ar_hs = 0, rresp_bad = 0;

  logic [31:0] exp_wr [4] = '{32'hdeadbeef, 32'hdeadbef0, 32'hdeadbef1, 32'hdeadbef2};

  axi4_master_slave dut (
    .aclk(aclk), .areset(areset), .start_write(start_write), .start_read(start_read),
    .write_done(write_done), .read_done(read_done), .busy(busy),
    .mem_dbg_addr(mem_dbg_addr), .mem_dbg_data(mem_dbg_data),
    .rbuf_dbg_addr(rbuf_dbg_addr), .rbuf_dbg_data(rbuf_dbg_data)
  );

  // Clock and watchdog
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Event monitor, sampled on the falling edge away from register updates
  always @(negedge aclk) begin
    if (write_done) wd_cnt++;
    if (read_done) rd_cnt++;
    if (dut.wvalid && dut.wready) w_beats++;
    if (dut.arvalid && dut.arready) ar_hs++;
    if (dut.rvalid && dut.rready) begin
      r_beats++;
      if (dut.rresp != 2'b00) rresp_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    repeat (n) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic peek_mem(input int i, output logic [31:0] d);
    mem_dbg_addr = 8'(i);
    #1 d = mem_dbg_data;
  endtask

  task automatic peek_rbuf(input int i, output logic [31:0] d);
    rbuf_dbg_addr = 8'(i);
    #1 d = rbuf_dbg_data;
  endtask

  // Pulse the starts for one cycle, then count cycles to the wanted done pulse.
  // lat = 1 is the cycle right after the start pulse was sampled.
  task automatic start_and_wait(input logic sw, input logic sr, input logic want_w,
                                output int lat);
    @(posedge aclk); #1;
    start_write = sw;
    start_read  = sr;
    @(posedge aclk); #1;
    start_write = 1'b0;
    start_read  = 1'b0;
    lat = 1;
    while (!(want_w ? write_done : read_done) && lat < 40) begin
      @(posedge aclk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, nz, wd0, rd0, wb0, rb0, ar0;
    logic [31:0] d;

    // Reset held for 10 cycles
    do_reset(10);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_write_done", 32'(write_done), 32'd0);
    check("reset_read_done", 32'(read_done), 32'd0);
    nz = 0;
    for (int i = 0; i < 256; i++) begin
      peek_mem(i, d);
      if (d !== 32'd0) nz++;
    end
    check("reset_mem_clear", 32'(nz), 32'd0);
    nz = 0;
    for (int i = 0; i < 256; i++) begin
      peek_rbuf(i, d);
      if (d !== 32'd0) nz++;
    end
    check("reset_rbuf_clear", 32'(nz), 32'd0);
    check("reset_no_done", 32'(wd_cnt + rd_cnt), 32'd0);

    // Read before any write returns zeros with OKAY
    rb0 = r_beats;
    start_and_wait(1'b0, 1'b1, 1'b0, lat);
    check("rbw_latency", 32'(lat), 32'd6);
    check("rbw_beats", 32'(r_beats - rb0), 32'd4);
    check("rbw_rresp_okay", 32'(rresp_bad), 32'd0);
    for (int i = 4; i < 8; i++) begin
      peek_rbuf(i, d);
      check($sformatf("rbw_rbuf%0d", i), d, 32'd0);
    end

    // Write burst
    wb0 = w_beats;
    start_and_wait(1'b1, 1'b0, 1'b1, lat);
    check("wr_latency", 32'(lat), 32'd7);
    check("wr_beats", 32'(w_beats - wb0), 32'd4);
    @(posedge aclk); #1;
    check("wr_done_one_cycle", 32'(write_done), 32'd0);
    check("wr_busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      peek_mem(4 + i, d);
      check($sformatf("wr_mem%0d", 4 + i), d, exp_wr[i]);
    end
    peek_mem(3, d);
    check("wr_mem3_untouched", d, 32'd0);
    peek_mem(8, d);
    check("wr_mem8_untouched", d, 32'd0);

    // Read burst back
    start_and_wait(1'b0, 1'b1, 1'b0, lat);
    check("rd_latency", 32'(lat), 32'd6);
    for (int i = 0; i < 4; i++) begin
      peek_rbuf(4 + i, d);
      check($sformatf("rd_rbuf%0d", 4 + i), d, exp_wr[i]);
    end
    peek_rbuf(8, d);
    check("rd_rbuf8_untouched", d, 32'd0);

    // Both starts together: write wins; a start_read while busy is dropped
    wd0 = wd_cnt; rd0 = rd_cnt; ar0 = ar_hs;
    @(posedge aclk); #1;
    start_write = 1'b1;
    start_read  = 1'b1;
    @(posedge aclk); #1;
    start_write = 1'b0;
    start_read  = 1'b0;
    lat = 1;
    check("prio_busy", 32'(busy), 32'd1);
    @(posedge aclk); #1;
    lat = 2;
    start_read = 1'b1;
    @(posedge aclk); #1;
    lat = 3;
    start_read = 1'b0;
    while (!write_done && lat < 40) begin
      @(posedge aclk); #1;
      lat++;
    end
    check("prio_wr_latency", 32'(lat), 32'd7);
    repeat (12) @(posedge aclk);
    #1;
    check("prio_write_ran", 32'(wd_cnt - wd0), 32'd1);
    check("prio_read_ignored", 32'(rd_cnt - rd0), 32'd0);
    check("prio_no_ar", 32'(ar_hs - ar0), 32'd0);
    check("prio_idle", 32'(busy), 32'd0);

    // Reset in the middle of the write data phase
    wd0 = wd_cnt;
    @(posedge aclk); #1;
    start_write = 1'b1;
    @(posedge aclk); #1;
    start_write = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    areset = 1'b1;
    @(posedge aclk); #1;
    check("mid_busy_after_reset", 32'(busy), 32'd0);
    areset = 1'b0;
    peek_mem(4, d);
    check("mid_mem4_cleared", d, 32'd0);
    repeat (10) @(posedge aclk);
    #1;
    check("mid_no_write_done", 32'(wd_cnt - wd0), 32'd0);
    start_and_wait(1'b1, 1'b0, 1'b1, lat);
    check("mid_rewrite_latency", 32'(lat), 32'd7);
    for (int i = 0; i < 4; i++) begin
      peek_mem(4 + i, d);
      check($sformatf("mid_mem%0d", 4 + i), d, exp_wr[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
